pkt_rx_ctrl: RTL and testbench
==============================

// Module: pkt_rx_ctrl
// PURPOSE
//  Ingress packet controller directly upstream of the per-port synchronous FIFO.
//  - Accepts a byte stream, parses header / payload / CRC and writes every byte into the FIFO.
//  - Commits a packet with a good CRC-8 (fifo_wr_ptr_upd); rewinds a packet with a bad CRC (fifo_flush).
//  - Admits a packet only when the FIFO has room for all of it.
// PARAMETERS
//  DATA_WIDTH     8  byte width; fixed at 8 (CRC-8)
//  POINTER_WIDTH  6  FIFO pointer width; FIFO depth = 2**POINTER_WIDTH
//  CNT_WIDTH     16  statistics counter width (ROUTER_PKT_STATS_EN only)
// PORTS
//  clk              in   1              clock, rising edge
//  rst              in   1              synchronous reset, active-high
//  in_data          in   DATA_WIDTH     ingress byte
//  in_valid         in   1              in_data valid
//  in_ready         out  1              byte accepted when in_valid & in_ready
//  fifo_level       in   POINTER_WIDTH  FIFO occupancy
//  fifo_data        out  DATA_WIDTH     byte to FIFO
//  fifo_push        out  1              write fifo_data
//  fifo_wr_ptr_upd  out  1              1-cycle pulse: commit packet
//  fifo_flush       out  1              1-cycle pulse: discard uncommitted packet
//  pkt_good         out  1              1-cycle pulse: packet committed
//  pkt_bad          out  1              1-cycle pulse: packet dropped (bad CRC or len 0)
//  good_cnt/bad_cnt out  CNT_WIDTH      saturating counters (ROUTER_PKT_STATS_EN only)
// BEHAVIOUR
//  Packet format: hdr, len payload bytes, crc.
//  - hdr[7:2] = len (1..63); hdr[1:0] = dest.
//  - crc = CRC-8, poly 0x07, init 0x00, MSB-first, computed over hdr + payload.
//  Reset: state IDLE; all outputs 0 except in_ready=1; crc_r, hdr_r and len counter cleared.
//  All FIFO outputs are registered: a byte accepted in cycle N appears on fifo_push/fifo_data in N+1.
//  FSM:
//  - IDLE: in_ready=1. On accept:
//      len==0 -> pkt_bad pulse next cycle; nothing pushed; stay IDLE.
//      else   -> store hdr_r; go to SPACE.
//  - SPACE: in_ready=0. Wait until (len+2) <= (2**POINTER_WIDTH-1 - fifo_level).
//      Compare in POINTER_WIDTH+2 bits, no wrap.
//      When true: push hdr_r, crc_r <= crc(0,hdr_r), go to PAYLOAD.
//  - PAYLOAD: in_ready=1. Each accepted byte is pushed and folded into crc_r; remaining-count decrements.
//      Gaps in in_valid allowed; state held.
//      Last payload byte accepted -> CRC.
//  - CRC: in_ready=1. Accepted byte is pushed, compared with crc_r into a match flag, go to COMMIT.
//  - COMMIT: in_ready=0, one cycle.
//      match  -> fifo_wr_ptr_upd=1, pkt_good=1.
//      !match -> fifo_flush=1, pkt_bad=1.
//      Then IDLE.
//  Timing / boundaries:
//  - Commit/flush pulse is asserted 2 cycles after the CRC byte is accepted, 1 cycle after its push.
//  - fifo_push never asserted while fifo_full=1; guaranteed by the SPACE check.
//  - fifo_wr_ptr_upd and fifo_flush are never both 1.
//  - At most one packet is in flight.
//  - rst mid-packet: return to IDLE; no commit is issued, so the partial packet stays uncommitted in the FIFO.
//  - crc_r is 8 bits; the len counter is 6 bits and never wraps (exits at 1).
// CONFIGURATION
//  ROUTER_PKT_STATS_EN defined:
//  - good_cnt/bad_cnt ports exist.
//  - +1 on each pkt_good/pkt_bad pulse; saturate at all-ones; cleared by rst.
//  ROUTER_PKT_STATS_EN undefined:
//  - Ports and counters absent; all other behaviour identical.
// STRUCTURE
//  router_pkg:
//  - CRC8_POLY=8'h07
//  - HDR_LEN_MSB/LSB=7/2, HDR_DEST_MSB/LSB=1/0
//  - state localparams IDLE/SPACE/PAYLOAD/CRC/COMMIT (3-bit)
//  Sub-module crc8_update: combinational (crc_in, byte) -> crc_out; one instance, shared by the hdr and payload paths.
// TESTING
//  1. Packet hdr=8'h0D (len 3, dest 1), payload 11 22 33, correct CRC, level 0
//     -> 5 pushes in order, then one fifo_wr_ptr_upd and pkt_good; no flush.
//  2. Same packet, CRC byte XOR 8'h01
//     -> 5 pushes, then fifo_flush + pkt_bad in the COMMIT cycle; no wr_ptr_upd.
//  3. hdr=8'h02 (len 0)
//     -> no push; pkt_bad pulse next cycle; in_ready stays 1.
//  4. fifo_level=60, len 4 (needs 6, free 3)
//     -> stalls in SPACE with in_ready=0 and no push; level driven to 57 -> header pushed next cycle.
//  5. Random in_valid gaps mid-payload
//     -> push count = bytes accepted; CRC still good; commit 2 cycles after the CRC byte.
//  6. rst asserted mid-payload, then a clean packet
//     -> no commit/flush for the first; second commits normally; STATS_EN: good_cnt=1, bad_cnt=0.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and FSM state encoding for the packet ingress controller
//
// Purpose : CRC-8 polynomial, header field positions and the pkt_rx_ctrl state encoding.
// Ports   : none (package).
package router_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPACE   = 3'd1,
    PAYLOAD = 3'd2,
    CRC     = 3'd3,
    COMMIT  = 3'd4
  } state_t;

endpackage

// File: rtl/crc8_update.sv
// rtl/crc8_update.sv - combinational CRC-8 (poly 0x07, MSB-first) single-byte update
//
// Purpose : folds one byte into a running CRC-8 value.
// Ports   : i_crc  [7:0] in   running CRC before this byte
//           i_byte [7:0] in   byte to fold in
//           o_crc  [7:0] out  running CRC after this byte
module crc8_update
  import router_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_byte,
  output logic [7:0] o_crc
);

  logic [7:0] w_c;

  always_comb begin
    w_c = i_crc ^ i_byte;
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[7] ? ({w_c[6:0], 1'b0} ^ CRC8_POLY) : {w_c[6:0], 1'b0};
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/pkt_rx_ctrl.sv
// rtl/pkt_rx_ctrl.sv - ingress packet controller: parse, space check, CRC-8 verify, FIFO commit/flush
//
// Purpose : accepts hdr/payload/crc byte packets, writes every byte into the downstream FIFO,
//           commits good-CRC packets and flushes bad ones. A packet is admitted only when the
//           FIFO has room for all of it. Optional feature macro: ROUTER_PKT_STATS_EN
//           (adds saturating good/bad packet counters and the CNT_WIDTH parameter).
// Ports   : clk             in   clock, rising edge
//           rst             in   synchronous reset, active-high
//           in_data         in   ingress byte
//           in_valid        in   in_data valid
//           in_ready        out  byte accepted when in_valid & in_ready
//           fifo_level      in   FIFO occupancy
//           fifo_data       out  byte to FIFO (registered)
//           fifo_push       out  write fifo_data (registered)
//           fifo_wr_ptr_upd out  1-cycle pulse: commit packet
//           fifo_flush      out  1-cycle pulse: discard uncommitted packet
//           pkt_good        out  1-cycle pulse: packet committed
//           pkt_bad         out  1-cycle pulse: packet dropped (bad CRC or len 0)
//           good_cnt        out  saturating good-packet count (ROUTER_PKT_STATS_EN only)
//           bad_cnt         out  saturating bad-packet count  (ROUTER_PKT_STATS_EN only)
module pkt_rx_ctrl
  import router_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 6
`ifdef ROUTER_PKT_STATS_EN
  ,
  parameter int CNT_WIDTH     = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [POINTER_WIDTH-1:0] fifo_level,
  output logic [DATA_WIDTH-1:0]    fifo_data,
  output logic                     fifo_push,
  output logic                     fifo_wr_ptr_upd,
  output logic                     fifo_flush,
  output logic                     pkt_good,
  output logic                     pkt_bad
`ifdef ROUTER_PKT_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]     good_cnt,
  output logic [CNT_WIDTH-1:0]     bad_cnt
`endif
);

  // Two extra bits so len+2 and the free-slot count never wrap.
  localparam int CMP_W = POINTER_WIDTH + 2;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hdr, w_hdr_nxt;
  logic [DATA_WIDTH-1:0] r_crc, w_crc_nxt;
  logic [HDR_LEN_W-1:0]  r_len, w_len_nxt;
  logic                  r_match, w_match_nxt;

  logic [DATA_WIDTH-1:0] r_fifo_data, w_fifo_data_nxt;
  logic                  r_fifo_push, w_fifo_push_nxt;
  logic                  r_wr_ptr_upd, w_wr_ptr_upd_nxt;
  logic                  r_flush, w_flush_nxt;
  logic                  r_pkt_good, w_pkt_good_nxt;
  logic                  r_pkt_bad, w_pkt_bad_nxt;

  logic [DATA_WIDTH-1:0] w_crc_in, w_crc_byte, w_crc_out;
  logic [CMP_W-1:0]      w_need, w_free;
  logic                  w_room;

  // One CRC engine: in SPACE it seeds from the stored header, otherwise it folds the ingress byte.
  assign w_crc_in   = (r_state == SPACE) ? '0 : r_crc;
  assign w_crc_byte = (r_state == SPACE) ? r_hdr : in_data;

  crc8_update u_crc8 (
    .i_crc  (w_crc_in),
    .i_byte (w_crc_byte),
    .o_crc  (w_crc_out)
  );

  // Whole packet (hdr + payload + crc) must fit in depth-1 minus current occupancy.
  assign w_need = CMP_W'(r_len) + CMP_W'(2);
  assign w_free = CMP_W'((2 ** POINTER_WIDTH) - 1) - CMP_W'(fifo_level);
  assign w_room = (w_need <= w_free);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hdr        <= '0;
      r_crc        <= '0;
      r_len        <= '0;
      r_match      <= 1'b0;
      r_fifo_data  <= '0;
      r_fifo_push  <= 1'b0;
      r_wr_ptr_upd <= 1'b0;
      r_flush      <= 1'b0;
      r_pkt_good   <= 1'b0;
      r_pkt_bad    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hdr        <= w_hdr_nxt;
      r_crc        <= w_crc_nxt;
      r_len        <= w_len_nxt;
      r_match      <= w_match_nxt;
      r_fifo_data  <= w_fifo_data_nxt;
      r_fifo_push  <= w_fifo_push_nxt;
      r_wr_ptr_upd <= w_wr_ptr_upd_nxt;
      r_flush      <= w_flush_nxt;
      r_pkt_good   <= w_pkt_good_nxt;
      r_pkt_bad    <= w_pkt_bad_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_hdr_nxt        = r_hdr;
    w_crc_nxt        = r_crc;
    w_len_nxt        = r_len;
    w_match_nxt      = r_match;
    w_fifo_data_nxt  = r_fifo_data;
    w_fifo_push_nxt  = 1'b0;
    w_wr_ptr_upd_nxt = 1'b0;
    w_flush_nxt      = 1'b0;
    w_pkt_good_nxt   = 1'b0;
    w_pkt_bad_nxt    = 1'b0;
    in_ready         = 1'b0;

    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data[HDR_LEN_MSB:HDR_LEN_LSB] == '0) begin
            w_pkt_bad_nxt = 1'b1;
          end else begin
            w_hdr_nxt   = in_data;
            w_len_nxt   = in_data[HDR_LEN_MSB:HDR_LEN_LSB];
            w_state_nxt = SPACE;
          end
        end
      end

      SPACE: begin
        if (w_room) begin
          w_fifo_push_nxt = 1'b1;
          w_fifo_data_nxt = r_hdr;
          w_crc_nxt       = w_crc_out;
          w_state_nxt     = PAYLOAD;
        end
      end

      PAYLOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_fifo_push_nxt = 1'b1;
          w_fifo_data_nxt = in_data;
          w_crc_nxt       = w_crc_out;
          // Counter leaves at 1 rather than decrementing to 0, so it never wraps.
          if (r_len == HDR_LEN_W'(1)) begin
            w_state_nxt = CRC;
          end else begin
            w_len_nxt = r_len - HDR_LEN_W'(1);
          end
        end
      end

      CRC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_fifo_push_nxt = 1'b1;
          w_fifo_data_nxt = in_data;
          w_match_nxt     = (in_data == r_crc);
          w_state_nxt     = COMMIT;
        end
      end

      COMMIT: begin
        if (r_match) begin
          w_wr_ptr_upd_nxt = 1'b1;
          w_pkt_good_nxt   = 1'b1;
        end else begin
          w_flush_nxt   = 1'b1;
          w_pkt_bad_nxt = 1'b1;
        end
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign fifo_data       = r_fifo_data;
  assign fifo_push       = r_fifo_push;
  assign fifo_wr_ptr_upd = r_wr_ptr_upd;
  assign fifo_flush      = r_flush;
  assign pkt_good        = r_pkt_good;
  assign pkt_bad         = r_pkt_bad;

`ifdef ROUTER_PKT_STATS_EN
  logic [CNT_WIDTH-1:0] r_good_cnt, r_bad_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      if (r_pkt_good && (r_good_cnt != '1)) r_good_cnt <= r_good_cnt + CNT_WIDTH'(1);
      if (r_pkt_bad  && (r_bad_cnt  != '1)) r_bad_cnt  <= r_bad_cnt  + CNT_WIDTH'(1);
    end
  end

  assign good_cnt = r_good_cnt;
  assign bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// tb/tb_pkt_rx_ctrl.sv - self-checking bench for pkt_rx_ctrl with a FIFO-push scoreboard
module tb_pkt_rx_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] fifo_level;
  logic [7:0] fifo_data;
  logic       fifo_push;
  logic       fifo_wr_ptr_upd;
  logic       fifo_flush;
  logic       pkt_good;
  logic       pkt_bad;
`ifdef ROUTER_PKT_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
`endif

  pkt_rx_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .fifo_level      (fifo_level),
    .fifo_data       (fifo_data),
    .fifo_push       (fifo_push),
    .fifo_wr_ptr_upd (fifo_wr_ptr_upd),
    .fifo_flush      (fifo_flush),
    .pkt_good        (pkt_good),
    .pkt_bad         (pkt_bad)
`ifdef ROUTER_PKT_STATS_EN
    ,
    .good_cnt        (good_cnt),
    .bad_cnt         (bad_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_push   = 0;
  int n_upd    = 0;
  int n_flush  = 0;
  int exp_push = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pl[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    return x;
  endfunction

  // Scoreboard: every FIFO push must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_push) begin
        n_push++;
        chk("push_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("push_data", fifo_data, exp_q.pop_front());
      end
      if (fifo_wr_ptr_upd) n_upd++;
      if (fifo_flush) n_flush++;
      if (fifo_wr_ptr_upd || fifo_flush) chk("upd_flush_excl", fifo_wr_ptr_upd & fifo_flush, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [7:0] b);
    exp_q.push_back(b);
    exp_push++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk("accept_timeout", n < 200, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] hdr, output logic [7:0] c);
    expect_push(hdr);
    c = crc8_step(8'h00, hdr);
    send_byte(hdr);
  endtask

  // Sends pl[] then the CRC (optionally corrupted), and checks commit/flush timing.
  task automatic send_body(input logic [7:0] c_in, input logic [7:0] flip, input int max_gap);
    logic [7:0] c;
    logic [7:0] cb;
    logic       good;
    c = c_in;
    foreach (pl[i]) begin
      repeat ($urandom_range(max_gap, 0)) step();
      expect_push(pl[i]);
      c = crc8_step(c, pl[i]);
      send_byte(pl[i]);
    end
    repeat ($urandom_range(max_gap, 0)) step();
    cb   = c ^ flip;
    good = (flip == 8'h00);
    expect_push(cb);
    send_byte(cb);
    chk("crc_push_n1", fifo_push, 1);
    chk("no_commit_n1", {fifo_wr_ptr_upd, fifo_flush}, 2'b00);
    step();
    chk("wr_ptr_upd_n2", fifo_wr_ptr_upd, good);
    chk("flush_n2", fifo_flush, !good);
    chk("pkt_good_n2", pkt_good, good);
    chk("pkt_bad_n2", pkt_bad, !good);
    step();
    chk("pulses_end", {fifo_wr_ptr_upd, fifo_flush, pkt_good, pkt_bad}, 4'b0000);
  endtask

  initial begin
    logic [7:0] c;
    int p0, u0, f0;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; fifo_level = 6'd0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {fifo_push, fifo_wr_ptr_upd, fifo_flush, pkt_good, pkt_bad}, 5'b00000);
    chk("rst_fifo_data", fifo_data, 8'h00);
    rst = 1'b0;
    step();

    // 1: good packet, len 3
    p0 = n_push; u0 = n_upd; f0 = n_flush;
    pl = '{8'h11, 8'h22, 8'h33};
    send_hdr(8'h0D, c);
    send_body(c, 8'h00, 0);
    chk("t1_pushes", n_push - p0, 5);
    chk("t1_upd_cnt", n_upd - u0, 1);
    chk("t1_flush_cnt", n_flush - f0, 0);

    // 2: same packet, CRC corrupted
    p0 = n_push; u0 = n_upd; f0 = n_flush;
    send_hdr(8'h0D, c);
    send_body(c, 8'h01, 0);
    chk("t2_pushes", n_push - p0, 5);
    chk("t2_upd_cnt", n_upd - u0, 0);
    chk("t2_flush_cnt", n_flush - f0, 1);

    // 3: zero-length header
    p0 = n_push;
    send_byte(8'h02);
    chk("t3_pkt_bad", pkt_bad, 1);
    chk("t3_in_ready", in_ready, 1);
    chk("t3_no_push", fifo_push, 0);
    step();
    chk("t3_pkt_bad_end", pkt_bad, 0);
    chk("t3_push_cnt", n_push - p0, 0);

    // 4: insufficient space stalls in SPACE until level falls to 57
    fifo_level = 6'd60;
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_hdr(8'h11, c);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_ready", in_ready, 0);
      chk("t4_stall_push", fifo_push, 0);
      step();
    end
    fifo_level = 6'd57;
    step();
    chk("t4_hdr_push", fifo_push, 1);
    chk("t4_hdr_data", fifo_data, 8'h11);
    fifo_level = 6'd0;
    send_body(c, 8'h00, 0);

    // 5: random in_valid gaps, len 7
    p0 = n_push;
    pl = {};
    for (int i = 0; i < 7; i++) pl.push_back(8'($urandom));
    send_hdr(8'h1E, c);
    send_body(c, 8'h00, 3);
    chk("t5_pushes", n_push - p0, 9);

    // 6: reset mid-payload, then a clean packet
    u0 = n_upd; f0 = n_flush;
    expect_push(8'h0D);
    send_byte(8'h0D);
    expect_push(8'h11);
    send_byte(8'h11);
    expect_push(8'h22);
    send_byte(8'h22);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("t6_ready_after_rst", in_ready, 1);
    repeat (4) step();
    chk("t6_no_upd", n_upd - u0, 0);
    chk("t6_no_flush", n_flush - f0, 0);
    pl = '{8'h11, 8'h22, 8'h33};
    send_hdr(8'h0D, c);
    send_body(c, 8'h00, 1);
    chk("t6_upd_after", n_upd - u0, 1);
`ifdef ROUTER_PKT_STATS_EN
    chk("t6_good_cnt", good_cnt, 16'd1);
    chk("t6_bad_cnt", bad_cnt, 16'd0);
`endif

    step();
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_push_total", n_push, exp_push);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
